// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared types for the commit trace unit:
//   trc_type_e : kind of trace record (register write, load, store, halt)
//   trc_rec_t  : packed 37-bit trace record {kind, rsel, addr, value}
//   state_e    : control FSM states
//   CNT_*      : indices of the performance counters inside the counter bank
// -----------------------------------------------------------------------------
package trace_pkg;

  typedef enum logic [1:0] {
    TRC_REG   = 2'd0,
    TRC_LOAD  = 2'd1,
    TRC_STORE = 2'd2,
    TRC_HALT  = 2'd3
  } trc_type_e;

  // Field order defines the record layout seen on the trace port:
  // kind[36:35], rsel[34:32], addr[31:16], value[15:0].
  typedef struct packed {
    trc_type_e   kind;
    logic [2:0]  rsel;
    logic [15:0] addr;
    logic [15:0] value;
  } trc_rec_t;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam int NUM_CNT = 6;
  localparam int CNT_CYC = 0;
  localparam int CNT_INS = 1;
  localparam int CNT_ICR = 2;
  localparam int CNT_ICH = 3;
  localparam int CNT_DCR = 4;
  localparam int CNT_DCH = 5;

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Two-push / one-pop first-word-fall-through FIFO with registered storage.
//   clk, rst_n     : clock, asynchronous active-low reset (clears pointers only)
//   push0_i/_data  : first record to enqueue this cycle
//   push1_i/_data  : second record; only honoured together with push0_i and
//                    always placed behind it
//   pop_i          : dequeue the head record (ignored when empty)
//   head_o         : head record, forced to all zeros while empty
//   empty_o        : no record stored
//   count_o        : number of stored records (0..DEPTH)
// The caller guarantees it never pushes more records than there is room for,
// counting the slot released by a same-cycle pop.
// -----------------------------------------------------------------------------
module trace_fifo #(
  parameter int  DEPTH = 8,
  parameter type rec_t = logic [36:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push0_i,
  input  rec_t                   push0_data_i,
  input  logic                   push1_i,
  input  rec_t                   push1_data_i,
  input  logic                   pop_i,
  output rec_t                   head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // differing only in the MSB mean full.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_idx0, wr_idx1;
  logic          do_pop;
  rec_t          mem_q [DEPTH];
  rec_t          head_raw;

  assign wr_idx0  = wr_ptr_q[AW-1:0];
  assign wr_idx1  = wr_idx0 + AW'(1);
  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign count_o  = wr_ptr_q - rd_ptr_q;
  assign do_pop   = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push0_i) begin
      wr_ptr_d = push1_i ? (wr_ptr_q + PW'(2)) : (wr_ptr_q + PW'(1));
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: every slot is written before it becomes visible.
  always_ff @(posedge clk) begin
    if (push0_i) begin
      mem_q[wr_idx0] <= push0_data_i;
      if (push1_i) begin
        mem_q[wr_idx1] <= push1_data_i;
      end
    end
  end

  assign head_raw = mem_q[rd_ptr_q[AW-1:0]];
  assign head_o   = empty_o ? rec_t'('0) : head_raw;

endmodule

// File: rtl/commit_trace_unit.sv
// -----------------------------------------------------------------------------
// commit_trace_unit
// Samples the register-file write port, data-memory port and halt each cycle,
// packs them into trace records, buffers them in trace_fifo and drains them one
// per cycle over a valid/ready port. Also keeps saturating performance counters.
//
// Ports:
//   clk, rst_n                     : core clock, asynchronous active-low reset
//   reg_wr_en/sel/data             : register-file write port
//   mem_en/wr/addr/wdata/rdata     : data-memory access port
//   halt                           : halt pulse from memory/writeback stage
//   icache_*/dcache_*              : cache request / hit strobes
//   trc_valid/ready                : trace record handshake
//   trc_type/reg/addr/value        : trace record fields (zero when not valid)
//   overflow                       : sticky, a record was dropped
//   done                           : halt record consumed, unit idle
//   cyc_cnt .. dc_hit_cnt          : performance counters
//
// Build option: define TRACE_PERF_CNT_EN to implement the six counters; when it
// is not defined the counter outputs are tied to zero and everything else is
// unchanged.
// -----------------------------------------------------------------------------
module commit_trace_unit
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reg_wr_en,
  input  logic [2:0]       reg_wr_sel,
  input  logic [15:0]      reg_wr_data,
  input  logic             mem_en,
  input  logic             mem_wr,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  output logic             trc_valid,
  input  logic             trc_ready,
  output logic [1:0]       trc_type,
  output logic [2:0]       trc_reg,
  output logic [15:0]      trc_addr,
  output logic [15:0]      trc_value,
  output logic             overflow,
  output logic             done,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [CNT_W-1:0] ic_req_cnt,
  output logic [CNT_W-1:0] ic_hit_cnt,
  output logic [CNT_W-1:0] dc_req_cnt,
  output logic [CNT_W-1:0] dc_hit_cnt
);

  localparam int AW = $clog2(DEPTH);
  // Wide enough to hold DEPTH plus the slot released by a pop.
  localparam int FW = AW + 2;

  state_e        state_q, state_d;
  logic          overflow_q, overflow_d;

  trc_rec_t      reg_rec, mem_rec, halt_rec, head;
  trc_rec_t      push0_data, push1_data;
  logic          push0, push1;
  logic          pop, empty;
  logic [AW:0]   count;
  logic [FW-1:0] free;

  // ---------------------------------------------------------------------------
  // Record formation
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_rec       = '0;
    reg_rec.kind  = TRC_REG;
    reg_rec.rsel  = reg_wr_sel;
    reg_rec.value = reg_wr_data;

    mem_rec       = '0;
    mem_rec.kind  = mem_wr ? TRC_STORE : TRC_LOAD;
    mem_rec.addr  = mem_addr;
    mem_rec.value = mem_wr ? mem_wdata : mem_rdata;

    halt_rec      = '0;
    halt_rec.kind = TRC_HALT;
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  trace_fifo #(
    .DEPTH (DEPTH),
    .rec_t (trc_rec_t)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push0_i      (push0),
    .push0_data_i (push0_data),
    .push1_i      (push1),
    .push1_data_i (push1_data),
    .pop_i        (pop),
    .head_o       (head),
    .empty_o      (empty),
    .count_o      (count)
  );

  // trc_valid comes straight from FIFO state, never from trc_ready.
  assign pop  = !empty && trc_ready;
  assign free = FW'(DEPTH) - FW'(count) + FW'(pop);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    push0      = 1'b0;
    push1      = 1'b0;
    push0_data = reg_rec;
    push1_data = mem_rec;

    unique case (state_q)
      ST_RUN: begin
        // Records are kept in order until space runs out; later ones drop.
        if (reg_wr_en) begin
          if (free != '0) begin
            push0 = 1'b1;
            if (mem_en) begin
              if (free >= FW'(2)) begin
                push1 = 1'b1;
              end else begin
                overflow_d = 1'b1;
              end
            end
          end else begin
            overflow_d = 1'b1;
          end
        end else if (mem_en) begin
          push0_data = mem_rec;
          if (free != '0) begin
            push0 = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (halt) begin
          state_d = ST_HALT_PEND;
        end
      end

      ST_HALT_PEND: begin
        // The halt record is never dropped: wait here until a slot opens.
        push0_data = halt_rec;
        if (free != '0) begin
          push0   = 1'b1;
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (pop && (head.kind == TRC_HALT)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Trace port
  // ---------------------------------------------------------------------------
  assign trc_valid = !empty;
  assign trc_type  = head.kind;
  assign trc_reg   = head.rsel;
  assign trc_addr  = head.addr;
  assign trc_value = head.value;
  assign overflow  = overflow_q;
  assign done      = (state_q == ST_DONE);

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef TRACE_PERF_CNT_EN
  logic                          cnt_active;
  logic [NUM_CNT-1:0]            cnt_inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_vec;

  assign cnt_active       = (state_q == ST_RUN) || (state_q == ST_HALT_PEND);
  assign cnt_inc[CNT_CYC] = 1'b1;
  assign cnt_inc[CNT_INS] = halt || reg_wr_en || (mem_en && mem_wr);
  assign cnt_inc[CNT_ICR] = icache_req;
  assign cnt_inc[CNT_ICH] = icache_hit;
  assign cnt_inc[CNT_DCR] = dcache_req;
  assign cnt_inc[CNT_DCH] = dcache_hit;

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturate at all-ones rather than wrapping.
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_active && cnt_inc[gi] && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_vec[gi] = cnt_q;
  end

  assign cyc_cnt    = cnt_vec[CNT_CYC];
  assign inst_cnt   = cnt_vec[CNT_INS];
  assign ic_req_cnt = cnt_vec[CNT_ICR];
  assign ic_hit_cnt = cnt_vec[CNT_ICH];
  assign dc_req_cnt = cnt_vec[CNT_DCR];
  assign dc_hit_cnt = cnt_vec[CNT_DCH];
`else
  // Cache strobes only feed the counters; keep them visibly consumed.
  logic unused_perf_inputs;
  assign unused_perf_inputs = ^{icache_req, icache_hit, dcache_req, dcache_hit};

  assign cyc_cnt    = '0;
  assign inst_cnt   = '0;
  assign ic_req_cnt = '0;
  assign ic_hit_cnt = '0;
  assign dc_req_cnt = '0;
  assign dc_hit_cnt = '0;
`endif

endmodule

// File: tb/tb_commit_trace_unit.sv
// -----------------------------------------------------------------------------
// tb_commit_trace_unit
// Table-driven vectors, hand sequences for the multi-cycle corner cases, and a
// randomized run, all checked against a queue-based reference model. Counter
// expectations follow TRACE_PERF_CNT_EN (zero when it is not defined).
// -----------------------------------------------------------------------------
module tb_commit_trace_unit;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
`ifdef TRACE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int P_RUN   = 0;
  localparam int P_HPEND = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;
  localparam longint unsigned CMAX = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reg_wr_en, mem_en, mem_wr, halt, trc_ready;
  logic [2:0] reg_wr_sel;
  logic [15:0] reg_wr_data, mem_addr, mem_wdata, mem_rdata;
  logic icache_req, icache_hit, dcache_req, dcache_hit;
  logic trc_valid, overflow, done;
  logic [1:0] trc_type;
  logic [2:0] trc_reg;
  logic [15:0] trc_addr, trc_value;
  logic [CNT_W-1:0] cyc_cnt, inst_cnt, ic_req_cnt, ic_hit_cnt, dc_req_cnt, dc_hit_cnt;

  // Narrow-counter instance used only to observe saturation.
  logic [2:0] sat_cyc;
  logic [2:0] unused_sat_c1, unused_sat_c2, unused_sat_c3, unused_sat_c4, unused_sat_c5;
  logic unused_sat_valid, unused_sat_ovf, unused_sat_done;
  logic [1:0] unused_sat_type;
  logic [2:0] unused_sat_reg;
  logic [15:0] unused_sat_addr, unused_sat_value;

  always #5 clk = ~clk;

  commit_trace_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
    .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_type(trc_type),
    .trc_reg(trc_reg), .trc_addr(trc_addr), .trc_value(trc_value),
    .overflow(overflow), .done(done),
    .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt), .ic_req_cnt(ic_req_cnt),
    .ic_hit_cnt(ic_hit_cnt), .dc_req_cnt(dc_req_cnt), .dc_hit_cnt(dc_hit_cnt)
  );

  commit_trace_unit #(.DEPTH(4), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
    .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .trc_valid(unused_sat_valid), .trc_ready(trc_ready), .trc_type(unused_sat_type),
    .trc_reg(unused_sat_reg), .trc_addr(unused_sat_addr), .trc_value(unused_sat_value),
    .overflow(unused_sat_ovf), .done(unused_sat_done),
    .cyc_cnt(sat_cyc), .inst_cnt(unused_sat_c1), .ic_req_cnt(unused_sat_c2),
    .ic_hit_cnt(unused_sat_c3), .dc_req_cnt(unused_sat_c4), .dc_hit_cnt(unused_sat_c5)
  );

  typedef struct packed {
    logic [1:0]  t;
    logic [2:0]  r;
    logic [15:0] a;
    logic [15:0] v;
  } rec_t;

  typedef struct {
    logic        reg_wr_en;
    logic [2:0]  reg_wr_sel;
    logic [15:0] reg_wr_data;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        halt;
    logic        ready;
    logic        icache_req, icache_hit, dcache_req, dcache_hit;
  } in_t;

  typedef struct {
    in_t  in;
    logic exp_valid;
    rec_t exp_rec;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  rec_t            mq[$];
  int              m_phase;
  bit              m_ovf;
  longint unsigned m_cnt[6];

  function automatic in_t ev(input logic re, input logic [2:0] sel, input logic [15:0] d,
                             input logic me, input logic mw, input logic [15:0] a,
                             input logic [15:0] wd, input logic [15:0] rd,
                             input logic h, input logic rdy);
    in_t x;
    x.reg_wr_en = re; x.reg_wr_sel = sel; x.reg_wr_data = d;
    x.mem_en = me; x.mem_wr = mw; x.mem_addr = a; x.mem_wdata = wd; x.mem_rdata = rd;
    x.halt = h; x.ready = rdy;
    x.icache_req = 1'b0; x.icache_hit = 1'b0; x.dcache_req = 1'b0; x.dcache_hit = 1'b0;
    return x;
  endfunction

  function automatic in_t idle(input logic rdy);
    return ev(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, rdy);
  endfunction

  function automatic rec_t mk(input logic [1:0] t, input logic [2:0] r,
                              input logic [15:0] a, input logic [15:0] v);
    rec_t x;
    x.t = t; x.r = r; x.a = a; x.v = v;
    return x;
  endfunction

  function automatic longint unsigned sat_inc(input longint unsigned x, input bit en);
    return (en && x != CMAX) ? x + 1 : x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input in_t v);
    reg_wr_en = v.reg_wr_en; reg_wr_sel = v.reg_wr_sel; reg_wr_data = v.reg_wr_data;
    mem_en = v.mem_en; mem_wr = v.mem_wr; mem_addr = v.mem_addr;
    mem_wdata = v.mem_wdata; mem_rdata = v.mem_rdata; halt = v.halt; trc_ready = v.ready;
    icache_req = v.icache_req; icache_hit = v.icache_hit;
    dcache_req = v.dcache_req; dcache_hit = v.dcache_hit;
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = P_RUN;
    m_ovf = 1'b0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask

  // One clock edge of the specified behaviour, applied to the pre-edge state.
  task automatic model_edge(input in_t v);
    bit   pop;
    rec_t popped;
    rec_t news[$];
    popped = '0;
    pop = (mq.size() > 0) && v.ready;
    if (pop) begin
      popped = mq.pop_front();
      $display("trace pop: type=%0d reg=%0d addr=%h value=%h", popped.t, popped.r, popped.a, popped.v);
    end
    if (m_phase == P_RUN || m_phase == P_HPEND) begin
      m_cnt[0] = sat_inc(m_cnt[0], 1'b1);
      m_cnt[1] = sat_inc(m_cnt[1], v.halt || v.reg_wr_en || (v.mem_en && v.mem_wr));
      m_cnt[2] = sat_inc(m_cnt[2], v.icache_req);
      m_cnt[3] = sat_inc(m_cnt[3], v.icache_hit);
      m_cnt[4] = sat_inc(m_cnt[4], v.dcache_req);
      m_cnt[5] = sat_inc(m_cnt[5], v.dcache_hit);
    end
    case (m_phase)
      P_RUN: begin
        if (v.reg_wr_en) news.push_back(mk(2'd0, v.reg_wr_sel, 16'h0, v.reg_wr_data));
        if (v.mem_en) news.push_back(v.mem_wr ? mk(2'd2, 3'd0, v.mem_addr, v.mem_wdata)
                                              : mk(2'd1, 3'd0, v.mem_addr, v.mem_rdata));
        foreach (news[i]) begin
          if (mq.size() < DEPTH) mq.push_back(news[i]);
          else m_ovf = 1'b1;
        end
        if (v.halt) m_phase = P_HPEND;
      end
      P_HPEND: begin
        if (mq.size() < DEPTH) begin
          mq.push_back(mk(2'd3, 3'd0, 16'h0, 16'h0));
          m_phase = P_DRAIN;
        end
      end
      P_DRAIN: if (pop && popped.t == 2'd3) m_phase = P_DONE;
      default: ;
    endcase
  endtask

  task automatic check_model();
    rec_t exp_rec;
    exp_rec = (mq.size() > 0) ? mq[0] : '0;
    chk("m_valid", trc_valid, mq.size() > 0);
    chk("m_record", {trc_type, trc_reg, trc_addr, trc_value}, exp_rec);
    chk("m_overflow", overflow, m_ovf);
    chk("m_done", done, m_phase == P_DONE);
    chk("m_cyc", cyc_cnt, PERF ? m_cnt[0] : 0);
    chk("m_inst", inst_cnt, PERF ? m_cnt[1] : 0);
    chk("m_icache", {ic_req_cnt, ic_hit_cnt}, PERF ? {m_cnt[2][31:0], m_cnt[3][31:0]} : 64'd0);
    chk("m_dcache", {dc_req_cnt, dc_hit_cnt}, PERF ? {m_cnt[4][31:0], m_cnt[5][31:0]} : 64'd0);
  endtask

  task automatic step(input in_t v);
    drive(v);
    @(posedge clk);
    model_edge(v);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    drive(idle(1'b0));
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic in_t rnd_in(input int phase, input int cyc);
    in_t x;
    logic rdy;
    // Alternate windows of mostly-stalled and mostly-ready consumer.
    rdy = ((cyc / 40) % 3 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
    if (phase == P_HPEND) return idle(rdy);
    x = ev($urandom_range(1), 3'($urandom_range(7)), 16'($urandom), $urandom_range(1),
           $urandom_range(1), 16'($urandom), 16'($urandom), 16'($urandom),
           $urandom_range(79) == 0, rdy);
    x.icache_req = $urandom_range(1); x.icache_hit = $urandom_range(1);
    x.dcache_req = $urandom_range(1); x.dcache_hit = $urandom_range(1);
    return x;
  endfunction

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{ev(1, 3, 16'h1234, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1), 1, mk(2'd0, 3'd3, 16'h0, 16'h1234)};
    tbl[1]  = '{idle(1), 0, '0};
    tbl[2]  = '{ev(1, 5, 16'h00AA, 1, 0, 16'h0040, 16'h0, 16'hBEEF, 0, 0), 1, mk(2'd0, 3'd5, 16'h0, 16'h00AA)};
    tbl[3]  = '{idle(1), 1, mk(2'd1, 3'd0, 16'h0040, 16'hBEEF)};
    tbl[4]  = '{idle(0), 1, mk(2'd1, 3'd0, 16'h0040, 16'hBEEF)};
    tbl[5]  = '{idle(1), 0, '0};
    tbl[6]  = '{ev(0, 0, 16'h0, 1, 1, 16'h0100, 16'h5A5A, 16'hFFFF, 0, 1), 1, mk(2'd2, 3'd0, 16'h0100, 16'h5A5A)};
    tbl[7]  = '{ev(0, 0, 16'h0, 1, 0, 16'h0200, 16'h1111, 16'h0F0F, 0, 1), 1, mk(2'd1, 3'd0, 16'h0200, 16'h0F0F)};
    tbl[8]  = '{ev(1, 7, 16'hFFFF, 1, 1, 16'h8000, 16'h0001, 16'h2222, 0, 1), 1, mk(2'd0, 3'd7, 16'h0, 16'hFFFF)};
    tbl[9]  = '{idle(1), 1, mk(2'd2, 3'd0, 16'h8000, 16'h0001)};
    tbl[10] = '{idle(1), 0, '0};

    drive(idle(1'b0));
    @(negedge clk);
    do_reset();

    // Reset state
    chk("reset_valid", trc_valid, 1'b0);
    chk("reset_fields", {trc_type, trc_reg, trc_addr, trc_value}, 64'd0);
    chk("reset_flags", {overflow, done}, 2'b00);
    chk("reset_cyc", cyc_cnt, 64'd0);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].in);
      chk($sformatf("vec%0d_valid", i), trc_valid, tbl[i].exp_valid);
      chk($sformatf("vec%0d_rec", i), {trc_type, trc_reg, trc_addr, trc_value}, tbl[i].exp_rec);
    end
    chk("tbl_inst_cnt", inst_cnt, PERF ? 64'd4 : 64'd0);
    chk("tbl_cyc_cnt", cyc_cnt, PERF ? 64'd11 : 64'd0);
    chk("sat_cyc_cnt", sat_cyc, PERF ? 64'd7 : 64'd0);

    // Nine stores into an 8-deep FIFO with the consumer stalled
    do_reset();
    for (int i = 0; i < 9; i++)
      step(ev(0, 0, 16'h0, 1, 1, 16'h0100 + 16'(i), 16'hC000 + 16'(i), 16'h0, 0, 0));
    chk("ovf_set", overflow, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_order%0d", i), {trc_valid, trc_type, trc_reg, trc_addr, trc_value},
          {1'b1, mk(2'd2, 3'd0, 16'h0100 + 16'(i), 16'hC000 + 16'(i))});
      step(idle(1));
    end
    chk("ovf_ninth_absent", trc_valid, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);

    // One free slot with REG+LOAD in the same cycle: REG kept, LOAD dropped
    do_reset();
    for (int i = 0; i < 7; i++)
      step(ev(0, 0, 16'h0, 1, 1, 16'h0200 + 16'(i), 16'h0, 16'h0, 0, 0));
    chk("one_slot_pre_ovf", overflow, 1'b0);
    step(ev(1, 6, 16'h6666, 1, 0, 16'h0300, 16'h0, 16'h7777, 0, 0));
    chk("one_slot_ovf", overflow, 1'b1);
    for (int i = 0; i < 7; i++) step(idle(1));
    chk("one_slot_reg_kept", {trc_valid, trc_type, trc_reg, trc_addr, trc_value},
        {1'b1, mk(2'd0, 3'd6, 16'h0, 16'h6666)});
    step(idle(1));
    chk("one_slot_load_dropped", trc_valid, 1'b0);

    // Halt with a full FIFO and a stalled consumer
    do_reset();
    for (int i = 0; i < 8; i++)
      step(ev(1, 3'(i), 16'hA000 + 16'(i), 0, 0, 16'h0, 16'h0, 16'h0, 0, 0));
    step(ev(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 1, 0));
    for (int i = 0; i < 5; i++) step(idle(0));
    chk("halt_wait_head", {trc_valid, trc_type, trc_reg, trc_value}, {1'b1, 2'd0, 3'd0, 16'hA000});
    chk("halt_wait_done", done, 1'b0);
    for (int k = 0; k < 9; k++) begin
      if (k < 8)
        chk($sformatf("halt_rec%0d", k), {trc_valid, trc_type, trc_reg, trc_addr, trc_value},
            {1'b1, mk(2'd0, 3'(k), 16'h0, 16'hA000 + 16'(k))});
      else
        chk("halt_rec_halt", {trc_valid, trc_type, trc_reg, trc_addr, trc_value},
            {1'b1, mk(2'd3, 3'd0, 16'h0, 16'h0)});
      chk($sformatf("halt_done_low%0d", k), done, 1'b0);
      step(idle(1));
    end
    chk("halt_done_high", {done, trc_valid}, 2'b10);
    for (int i = 0; i < 5; i++)
      step(ev(1, 1, 16'h1, 1, 1, 16'h1, 16'h1, 16'h1, 1, 1));
    chk("halt_cyc_frozen", cyc_cnt, PERF ? 64'd15 : 64'd0);
    chk("halt_inst_frozen", inst_cnt, PERF ? 64'd9 : 64'd0);
    chk("halt_inputs_ignored", {done, trc_valid}, 2'b10);

    // Cache strobe counting
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_t x;
      x = idle(1);
      x.dcache_req = 1'b1;
      x.dcache_hit = (i < 7);
      x.icache_req = (i % 2 == 0);
      x.icache_hit = (i % 4 == 0);
      step(x);
    end
    chk("dc_req_cnt", dc_req_cnt, PERF ? 64'd10 : 64'd0);
    chk("dc_hit_cnt", dc_hit_cnt, PERF ? 64'd7 : 64'd0);
    chk("ic_cnts", {ic_req_cnt, ic_hit_cnt}, PERF ? {32'd5, 32'd3} : 64'd0);
    chk("cache_no_trace", trc_valid, 1'b0);

    // Reset asserted mid-drain
    do_reset();
    for (int i = 1; i <= 3; i++)
      step(ev(1, 3'(i), 16'h0 + 16'(i), 0, 0, 16'h0, 16'h0, 16'h0, 0, 0));
    step(ev(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 1, 0));
    step(idle(0));
    chk("drain_queued", trc_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", trc_valid, 1'b0);
    chk("async_rst_fields", {trc_type, trc_reg, trc_addr, trc_value, overflow, done}, 64'd0);
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    step(ev(1, 4, 16'h4444, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1));
    chk("post_rst_reg", {trc_valid, trc_type, trc_reg, trc_addr, trc_value},
        {1'b1, mk(2'd0, 3'd4, 16'h0, 16'h4444)});
    step(ev(0, 0, 16'h0, 1, 1, 16'h0AAA, 16'h0BBB, 16'h0, 0, 1));
    chk("post_rst_store", {trc_valid, trc_type, trc_reg, trc_addr, trc_value},
        {1'b1, mk(2'd2, 3'd0, 16'h0AAA, 16'h0BBB)});

    // Randomized run against the reference model
    do_reset();
    begin
      int done_cycles;
      done_cycles = 0;
      for (int c = 0; c < 1200; c++) begin
        if (m_phase == P_DONE) done_cycles++;
        if (done_cycles > 4) begin
          done_cycles = 0;
          do_reset();
        end else begin
          step(rnd_in(m_phase, c));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/commit_trace_unit.md
# commit_trace_unit

In-core producer of the architectural commit trace and performance counters, placed beside the writeback/memory stages of the processor. Each cycle it samples the register-file write port, the data-memory access port, the halt signal and the cache request/hit strobes. It packs register, load, store and halt events into records, buffers them in a small FIFO and drains them one per cycle over a valid/ready port. A downstream logger or checker consumes that port, so trace generation is synthesizable rather than probed hierarchically.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥4
- CNT_W, 32: performance counter width
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- reg_wr_en  in  1  register file write this cycle
- reg_wr_sel  in  3  destination register
- reg_wr_data  in  16  write data
- mem_en  in  1  data memory access this cycle
- mem_wr  in  1  1 = store, 0 = load (valid with mem_en)
- mem_addr  in  16  access address
- mem_wdata  in  16  store data
- mem_rdata  in  16  load data
- halt  in  1  halt in memory/writeback stage (pulse)
- icache_req, icache_hit, dcache_req, dcache_hit  in  1 each  cache strobes
- trc_valid  out  1  record available
- trc_ready  in  1  consumer accepts
- trc_type  out  2  0 REG, 1 LOAD, 2 STORE, 3 HALT
- trc_reg  out  3  register (REG only, else 0)
- trc_addr  out  16  address (LOAD/STORE, else 0)
- trc_value  out  16  data value
- overflow  out  1  sticky: a record was dropped
- done  out  1  halt record consumed, unit idle
- cyc_cnt, inst_cnt, ic_req_cnt, ic_hit_cnt, dc_req_cnt, dc_hit_cnt  out  CNT_W each  counters

## Operation
- States: RUN, HALT_PEND, DRAIN, DONE.
- RUN: each cycle forms up to two records, in order: REG if reg_wr_en, then LOAD/STORE if mem_en (value = mem_rdata for LOAD, mem_wdata for STORE). Both are enqueued in the same cycle when there is space.
- Free space counts the slot vacated by a same-cycle pop.
- If only one slot is free: REG is kept, MEM is dropped, overflow is set. If none are free: all records are dropped, overflow is set.
- halt in RUN: that cycle's REG/MEM records are still captured, then the state moves to HALT_PEND.
- HALT_PEND: enqueues one HALT record (all fields 0) when a slot is free, then moves to DRAIN. A HALT record is never dropped; the unit waits for space.
- Inputs are ignored outside RUN.
- DRAIN: moves to DONE on the cycle the HALT record is popped.
- DONE: terminal; done=1 and counters frozen until reset.
- Counters, updated in RUN and HALT_PEND only:
  - cyc_cnt increments every cycle.
  - inst_cnt increments when halt|reg_wr_en|(mem_en&mem_wr).
  - Cache counters increment on their strobes.
- All counters saturate at all-ones; no wrap.
- FIFO pointers are log2(DEPTH)+1 bits wide; full/empty are distinguished by the MSB.

## Timing
- Reset (async assert, sync-released): state RUN, FIFO empty, trc_valid=0, trc_* fields 0, overflow=0, done=0, all counters 0.
- Reset mid-drain discards all records.
- Latency: event sampled at edge N appears on trc_* after edge N (first-word-fall-through from registered FIFO storage).
- A second record from the same cycle appears after the first is popped.
- Handshake: a pop occurs on trc_valid&trc_ready. trc_* are stable while valid&!ready. trc_valid does not depend combinationally on trc_ready.
- Throughput: one pop per cycle, two pushes per cycle.
- Counters are registered and update the edge after the sampled strobe.
- done rises the edge after the HALT pop.

## Configuration
- TRACE_PERF_CNT_EN defined: all six counters are implemented as above.
- Not defined: the counter registers are removed, all counter outputs are tied to 0, and trace/FIFO/FSM behaviour is unchanged.

## Structure
- Package trace_pkg holds:
  - the trc_type enum (TRC_REG, TRC_LOAD, TRC_STORE, TRC_HALT)
  - the packed record struct (type, reg, addr, value; 37 bits)
  - the state enum
- Sub-module trace_fifo: a two-push, one-pop FIFO with count output, parameterized by DEPTH and record type.

## Test plan
- reg_wr_en=1, sel=3, data=0x1234, ready=1 → one REG record: reg 3, value 0x1234; inst_cnt=1.
- Same cycle: reg write (r5, 0x00AA) and load from 0x0040 returning 0xBEEF → REG then LOAD records on consecutive pops, in that order.
- ready=0, DEPTH=8, stores on 9 consecutive cycles → first 8 STORE records preserved in order, overflow=1, ninth record absent.
- halt with FIFO full and ready=0 for 5 cycles, then ready=1 → all prior records, then HALT; done=1 one cycle after the HALT pop; cyc_cnt frozen afterwards.
- dcache_req on 10 cycles, dcache_hit on 7, with macro defined → dc_req_cnt=10, dc_hit_cnt=7. With macro undefined → both 0, trace identical.
- rst_n asserted while 3 records are queued in DRAIN → trc_valid=0 immediately; after release, the state is RUN and a new event traces normally.
